// File: rtl/vga_scan_engine.sv
// VGA raster engine: h/v timing, VRAM read addressing with replication, and pixel output
// kept cycle-aligned to the VRAM read latency, with an optional blinking block cursor.
module vga_scan_engine #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int SCALE_LOG2 = 0,
  parameter int RAM_LAT    = 1,
  parameter int ADDR_W     = 19,
  parameter int CELL_LOG2  = 3,
  parameter bit CURSOR_EN  = 1'b1
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              Blink,
  input  logic [12:0]       Cursor,
  input  logic [11:0]       vram_out,
  output logic              vga_rdn,
  output logic [ADDR_W-1:0] vga_addr,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic              DE,
  output logic [3:0]        R,
  output logic [3:0]        G,
  output logic [3:0]        B,
  output logic              frame_start
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W      = $clog2(H_TOTAL);
  localparam int VC_W      = $clog2(V_TOTAL);
  localparam int AW1       = ADDR_W + 1;
  localparam int SRC_W     = H_ACTIVE >> SCALE_LOG2;
  localparam int CELL_COLS = SRC_W >> CELL_LOG2;
  localparam int CELL_SH   = SCALE_LOG2 + CELL_LOG2;
  localparam int CELL_W    = (HC_W + VC_W > 13) ? HC_W + VC_W : 13;

  localparam logic [HC_W-1:0] H_MAX       = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_SYNC_END  = HC_W'(H_SYNC);
  localparam logic [HC_W-1:0] H_ACT_FIRST = HC_W'(H_SYNC + H_BP);
  localparam logic [HC_W-1:0] H_ACT_LAST  = HC_W'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [VC_W-1:0] V_MAX       = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_SYNC_END  = VC_W'(V_SYNC);
  localparam logic [VC_W-1:0] V_ACT_FIRST = VC_W'(V_SYNC + V_BP);
  localparam logic [VC_W-1:0] V_ACT_LAST  = VC_W'(V_SYNC + V_BP + V_ACTIVE - 1);

  // Stage-0 attributes that must travel alongside the VRAM read.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic hit;
    logic first;
  } tap_t;

  logic [1:0]         rst_sync;
  logic               rst_int_n;
  logic [HC_W-1:0]    hc;
  logic [VC_W-1:0]    vc;
  logic [HC_W-1:0]    col;
  logic [VC_W-1:0]    row;
  logic               act0;
  logic [AW1-1:0]     addr0;
  logic [CELL_W-1:0]  cell0;
  tap_t               tap0;
  tap_t [RAM_LAT:0]   taps;
  tap_t               tap_out;
  logic [11:0]        pix;

  // NOTE: reset asserts asynchronously but releases on a clock edge, so every
  // flop below leaves reset in the same cycle regardless of when rst_n rises.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of block ordering.
  always_ff @(posedge vga_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_MAX) begin
      hc <= '0;
      vc <= (vc == V_MAX) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // NOTE: every signal is given a default at the top of the block so no
  // path through it can leave a value held, which would infer a latch.
  always_comb begin
    col   = hc - H_ACT_FIRST;
    row   = vc - V_ACT_FIRST;
    act0  = (hc >= H_ACT_FIRST) && (hc <= H_ACT_LAST) &&
            (vc >= V_ACT_FIRST) && (vc <= V_ACT_LAST);
    addr0 = AW1'(row >> SCALE_LOG2) * AW1'(SRC_W) + AW1'(col >> SCALE_LOG2);
    cell0 = CELL_W'(row >> CELL_SH) * CELL_W'(CELL_COLS) + CELL_W'(col >> CELL_SH);

    tap0       = '0;
    tap0.hs    = hc < H_SYNC_END;
    tap0.vs    = vc < V_SYNC_END;
    tap0.act   = act0;
    tap0.hit   = CURSOR_EN && act0 && Blink && (cell0 == CELL_W'(Cursor));
    tap0.first = act0 && (col == '0) && (row == '0);
  end

  always_ff @(posedge vga_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      vga_addr <= '0;
      vga_rdn  <= 1'b1;
    end else begin
      vga_addr <= act0 ? addr0[ADDR_W-1:0] : '0;
      vga_rdn  <= ~act0;
    end
  end

  // One stage for the address register plus RAM_LAT stages for the memory.
  always_ff @(posedge vga_clk or negedge rst_int_n) begin
    if (!rst_int_n) taps <= '0;
    else            taps <= {taps[RAM_LAT-1:0], tap0};
  end

  assign tap_out = taps[RAM_LAT];

  always_comb begin
    pix = '0;
    if (tap_out.act) pix = (tap_out.hit && Blink) ? ~vram_out : vram_out;
  end

  assign {B, G, R}   = pix;
  assign DE          = tap_out.act;
  assign HSYNC       = tap_out.hs ? HS_POL : ~HS_POL;
  assign VSYNC       = tap_out.vs ? VS_POL : ~VS_POL;
  assign frame_start = tap_out.first;

endmodule
